square_complex_seq: RTL
=======================

Name: square_complex_seq

Overview:
Parametrised, time-multiplexed successor to the fixed 4-channel combinational complex squarer. Accepts a vector of NCH signed complex samples over a valid/ready handshake and processes them serially through one pipelined multiplier pair. Returns the full result vector over a second valid/ready handshake. Runtime mode selects complex square or magnitude-squared; the magnitude-squared mode feeds the sorter front end.

Parameters:
WIDTH, 8, bit width of each signed real/imag input component (>=2)
NCH, 4, number of complex channels per vector (>=1)
OW (localparam), 2*WIDTH+1, output component width; exact, no saturation
CW (localparam), max(1,$clog2(NCH)), channel index counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_mode  in  1  0 = complex square, 1 = magnitude squared; sampled on acceptance
in_real  in  NCH*WIDTH  packed signed real parts, channel k at [k*WIDTH +: WIDTH]
in_imag  in  NCH*WIDTH  packed signed imag parts, same packing
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts result
out_mode  out  1  mode the result was computed with
out_real  out  NCH*OW  packed signed results, channel k at [k*OW +: OW]
out_imag  out  NCH*OW  packed signed results

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Arithmetic (signed two's complement, sign-extended to OW):
  - mode 0: real = re*re - im*im; imag = 2*re*im
  - mode 1: real = re*re + im*im; imag = 0
  - OW is sufficient for every input, including (-2^(W-1), -2^(W-1)). No overflow is possible.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid is high, capture in_real, in_imag and in_mode into input registers, clear index k, and go to BUSY. The capture edge is called edge 0.
  - BUSY: in_ready=0. Issue channel k at edge k+1 (products registered). At edge k+2, write the add/sub result to output buffer slot k. After the last write (edge NCH+1), go to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are held stable. When out_ready is high, return to IDLE at that edge.
- Latency: acceptance edge to out_valid high = NCH+1 cycles. Minimum vector period = NCH+3 cycles.
- Handshake:
  - in_ready depends only on state, never on in_valid.
  - out_valid never drops without out_ready.
  - in_* changes while not accepted are ignored.
  - out_ready while not in DONE is ignored.
- Reset values: state IDLE, out_valid=0, out_mode=0, out_real=0, out_imag=0, k=0, pipeline registers 0. in_ready=1 from the first edge after rst is released.
- Reset mid-operation (BUSY or DONE): the vector is abandoned and partial results are cleared to 0. No out_valid pulse follows.
- Output buffer slots are written only in BUSY. Slots not yet written hold the previous vector's values, which are not visible because out_valid=0.
- NCH=1: BUSY lasts 2 cycles and the index counter stays 0.

Decomposition:
- Shared package: mode constants (MODE_SQUARE=0, MODE_MAG2=1), FSM state enum, and OW/CW derivation functions.
- One sub-module, complex_sq_stage: 2-stage pipelined datapath.
  - Stage 1 registers re*re, im*im and re*im.
  - Stage 2 registers the mode-selected real/imag results.
  - Parametrised by WIDTH; no handshake inside.

Test Plan:
1. WIDTH=8, NCH=4, mode 0; ch0=(3,4), ch1=(-128,-128), ch2=(127,-128), ch3=(0,0) -> out real {-7, 0, -255, 0}, imag {24, 32768, -32512, 0}; out_mode=0.
2. Same vector, mode 1 -> real {25, 32768, 32513, 0}, imag all 0; out_mode=1.
3. Latency/throughput with out_ready held high and in_valid held high -> accept at edge 0, out_valid high after edge 5, next accept at edge 7; in_ready low in between.
4. Backpressure: hold out_ready low 10 cycles in DONE -> out_* stable, in_ready=0, a new in_valid is not accepted; release -> one transfer, then IDLE.
5. rst asserted one cycle at edge 2 of BUSY -> out_valid=0, outputs 0, in_ready=1. A following vector (5,-2) in mode 0 yields real 21, imag -20.
6. NCH=1, WIDTH=4, input (-8,-8) -> mode 0 gives real 0, imag 128; mode 1 gives real 128; out_valid 2 cycles after acceptance.

Source files
------------

// File: rtl/square_complex_seq_pkg.sv
// Shared definitions for the time-multiplexed complex squarer: mode encodings,
// FSM state type and width derivation helpers.
package square_complex_seq_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_MAG2   = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    function automatic int unsigned calc_ow(input int unsigned width);
        return 2 * width + 1;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/square_complex_seq_if.sv
// Input-vector and result-vector valid/ready channels of the complex squarer.
interface square_complex_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
);
    import square_complex_seq_pkg::*;

    localparam int unsigned OW = calc_ow(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [NCH*WIDTH-1:0] in_real;
    logic [NCH*WIDTH-1:0] in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_mode;
    logic [NCH*OW-1:0]    out_real;
    logic [NCH*OW-1:0]    out_imag;

    modport master (
        output in_valid, in_mode, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_mode, out_real, out_imag
    );

    modport slave (
        input  in_valid, in_mode, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_mode, out_real, out_imag
    );

endinterface

// File: rtl/square_complex_seq_complex_sq_stage.sv
// Shared multiplier pair: stage 1 registers re*re, im*im, re*im; the mode-selected
// sum/difference is presented combinationally and registered by the caller's output slot.
module complex_sq_stage
    import square_complex_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en_i,
    input  logic                               mode_i,
    input  logic signed [WIDTH-1:0]            re_i,
    input  logic signed [WIDTH-1:0]            im_i,
    output logic signed [calc_ow(WIDTH)-1:0]   res_re_o,
    output logic signed [calc_ow(WIDTH)-1:0]   res_im_o
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned OW = calc_ow(WIDTH);

    logic signed [PW-1:0] rr_q, ii_q, ri_q;
    logic signed [PW-1:0] rr_d, ii_d, ri_d;
    logic signed [OW-1:0] rr_x, ii_x, ri_x;

    always_comb begin
        rr_d = PW'(re_i) * PW'(re_i);
        ii_d = PW'(im_i) * PW'(im_i);
        ri_d = PW'(re_i) * PW'(im_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
        end else if (en_i) begin
            rr_q <= rr_d;
            ii_q <= ii_d;
            ri_q <= ri_d;
        end
    end

    always_comb begin
        rr_x = OW'(rr_q);
        ii_x = OW'(ii_q);
        ri_x = OW'(ri_q);
        if (mode_i == MODE_SQUARE) begin
            res_re_o = rr_x - ii_x;
            res_im_o = ri_x <<< 1;
        end else begin
            res_re_o = rr_x + ii_x;
            res_im_o = '0;
        end
    end

endmodule

// File: rtl/square_complex_seq.sv
// Vector complex squarer: captures NCH samples, streams them through one multiplier
// pair, and holds the full result vector until the consumer takes it.
module square_complex_seq
    import square_complex_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    square_complex_seq_if.slave bus
);
    localparam int unsigned   OW     = calc_ow(WIDTH);
    localparam int unsigned   CW     = calc_cw(NCH);
    localparam logic [CW-1:0] LastCh = CW'(NCH - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        k_q, k_d, wr_idx_q, wr_idx_d;
    logic                 issuing_q, issuing_d, s1_vld_q, s1_vld_d;
    logic                 mode_q, mode_d, out_mode_q, out_mode_d;
    logic [NCH*WIDTH-1:0] real_q, real_d, imag_q, imag_d;
    logic [NCH*OW-1:0]    out_real_q, out_real_d, out_imag_q, out_imag_d;
    logic                 issue_en;
    logic signed [WIDTH-1:0] ch_re, ch_im;
    logic signed [OW-1:0]    res_re, res_im;
    int unsigned          k_idx, wr_idx;

    assign k_idx  = 32'(k_q);
    assign wr_idx = 32'(wr_idx_q);
    assign ch_re  = real_q[k_idx*WIDTH +: WIDTH];
    assign ch_im  = imag_q[k_idx*WIDTH +: WIDTH];

    complex_sq_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en_i     (issue_en),
        .mode_i   (mode_q),
        .re_i     (ch_re),
        .im_i     (ch_im),
        .res_re_o (res_re),
        .res_im_o (res_im)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wr_idx_d   = wr_idx_q;
        issuing_d  = issuing_q;
        s1_vld_d   = 1'b0;
        mode_d     = mode_q;
        real_d     = real_q;
        imag_d     = imag_q;
        out_real_d = out_real_q;
        out_imag_d = out_imag_q;
        out_mode_d = out_mode_q;
        issue_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    real_d    = bus.in_real;
                    imag_d    = bus.in_imag;
                    mode_d    = bus.in_mode;
                    k_d       = '0;
                    issuing_d = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                // Issue and write-back overlap: slot k is written while channel k+1 issues.
                if (issuing_q) begin
                    issue_en = 1'b1;
                    s1_vld_d = 1'b1;
                    wr_idx_d = k_q;
                    if (k_q == LastCh) issuing_d = 1'b0;
                    else               k_d = k_q + CW'(1);
                end
                if (s1_vld_q) begin
                    out_real_d[wr_idx*OW +: OW] = res_re;
                    out_imag_d[wr_idx*OW +: OW] = res_im;
                    if (wr_idx_q == LastCh) begin
                        out_mode_d = mode_q;
                        state_d    = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            k_q        <= '0;
            wr_idx_q   <= '0;
            issuing_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            mode_q     <= 1'b0;
            real_q     <= '0;
            imag_q     <= '0;
            out_real_q <= '0;
            out_imag_q <= '0;
            out_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wr_idx_q   <= wr_idx_d;
            issuing_q  <= issuing_d;
            s1_vld_q   <= s1_vld_d;
            mode_q     <= mode_d;
            real_q     <= real_d;
            imag_q     <= imag_d;
            out_real_q <= out_real_d;
            out_imag_q <= out_imag_d;
            out_mode_q <= out_mode_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_mode  = out_mode_q;
    assign bus.out_real  = out_real_q;
    assign bus.out_imag  = out_imag_q;

endmodule
